// File: rtl/boxhead_sprite_pkg.sv
// rtl/boxhead_sprite_pkg.sv - shared types and constants for the player sprite engine
// Purpose: direction, animation and flash state encodings plus the transparent
// palette index, imported by player_sprite_engine and sprite_anim_ctrl.
// Ports: none (package).
package boxhead_sprite_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } anim_state_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FLASH  = 1'b1
  } flash_state_t;

  localparam logic [4:0] TRANSPARENT_IDX = 5'd0;

endpackage

// File: rtl/sprite_anim_ctrl.sv
// rtl/sprite_anim_ctrl.sv - walk-animation and hit-flash FSMs stepped by the game-frame tick
// Purpose: advances the walk frame while moving and blinks the sprite after a hit.
// Ports:
//   Clk, Reset (async, active low)
//   game_frame_clk_rising_edge  one-cycle tick per game frame
//   is_moving, hit              player status inputs (hit is a one-cycle pulse)
//   anim_frame                  current walk frame
//   hidden                      sprite suppressed for this blink phase
module sprite_anim_ctrl
  import boxhead_sprite_pkg::*;
#(
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_HOLD  = 8,
  parameter int FLASH_TICKS = 16,
  localparam int FW = $clog2(NUM_FRAMES),
  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1,
  localparam int CW = $clog2(FLASH_TICKS + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          game_frame_clk_rising_edge,
  input  logic          is_moving,
  input  logic          hit,
  output logic [FW-1:0] anim_frame,
  output logic          hidden
);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(FRAME_HOLD - 1);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
  localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_TICKS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_TWO    = CW'(2);

  anim_state_t  anim_state, anim_state_next;
  logic [HW-1:0] hold_cnt, hold_cnt_next;
  logic [FW-1:0] frame, frame_next;

  flash_state_t flash_state, flash_state_next;
  logic [CW-1:0] flash_cnt, flash_cnt_next;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      anim_state  <= IDLE;
      hold_cnt    <= '0;
      frame       <= '0;
      flash_state <= NORMAL;
      flash_cnt   <= '0;
    end else begin
      anim_state  <= anim_state_next;
      hold_cnt    <= hold_cnt_next;
      frame       <= frame_next;
      flash_state <= flash_state_next;
      flash_cnt   <= flash_cnt_next;
    end
  end

  always_comb begin
    anim_state_next = anim_state;
    hold_cnt_next   = hold_cnt;
    frame_next      = frame;
    if (game_frame_clk_rising_edge) begin
      case (anim_state)
        IDLE: begin
          hold_cnt_next = '0;
          frame_next    = '0;
          if (is_moving) anim_state_next = WALK;
        end
        WALK: begin
          if (!is_moving) begin
            anim_state_next = IDLE;
            hold_cnt_next   = '0;
            frame_next      = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            hold_cnt_next = '0;
            frame_next    = frame + FRAME_ONE;  // power-of-2 frame count wraps naturally
          end else begin
            hold_cnt_next = hold_cnt + HOLD_ONE;
          end
        end
        default: anim_state_next = IDLE;
      endcase
    end
  end

  // A hit always reloads the count and pre-empts a coincident tick.
  // The flash ends on the tick that would take the count down to 1.
  always_comb begin
    flash_state_next = flash_state;
    flash_cnt_next   = flash_cnt;
    if (hit) begin
      flash_state_next = FLASH;
      flash_cnt_next   = FLASH_LOAD;
    end else if (game_frame_clk_rising_edge && flash_state == FLASH) begin
      if (flash_cnt <= CNT_TWO) begin
        flash_state_next = NORMAL;
        flash_cnt_next   = '0;
      end else begin
        flash_cnt_next = flash_cnt - CNT_ONE;
      end
    end
  end

  assign anim_frame = frame;
  assign hidden     = (flash_state == FLASH) && flash_cnt[2];

endmodule

// File: rtl/player_sprite_engine.sv
// rtl/player_sprite_engine.sv - player bounding-box test, sprite-ROM addressing and palette output
// Purpose: 3-stage free-running pixel pipeline feeding is_player/player_index to the colour mapper.
// Optional feature macro: PLAYER_MIRROR_EN (left-facing sprite drawn by mirroring the right rows).
// Ports:
//   Clk, Reset (async, active low), game_frame_clk_rising_edge (frame tick)
//   DrawX, DrawY          current pixel
//   player_x, player_y    sprite top-left corner
//   direction, is_moving, hit
//   rom_addr / rom_data   synchronous sprite ROM (data one Clk after address)
//   is_player, player_index, anim_frame
module player_sprite_engine
  import boxhead_sprite_pkg::*;
#(
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_HOLD  = 8,
  parameter int FLASH_TICKS = 16,
  parameter int ADDR_W      = 14,
  localparam int FW = $clog2(NUM_FRAMES)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              game_frame_clk_rising_edge,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        player_x,
  input  logic [9:0]        player_y,
  input  logic [1:0]        direction,
  input  logic              is_moving,
  input  logic              hit,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_data,
  output logic              is_player,
  output logic [4:0]        player_index,
  output logic [FW-1:0]     anim_frame
);

  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);

  logic          hidden;
  logic [9:0]    lx, ly;
  logic          in_box;
  logic [1:0]    addr_dir;
  logic [XW-1:0] addr_x;
  logic          in_box1, hidden1, in_box2, hidden2;

  sprite_anim_ctrl #(
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_HOLD  (FRAME_HOLD),
    .FLASH_TICKS (FLASH_TICKS)
  ) u_anim_ctrl (
    .Clk                        (Clk),
    .Reset                      (Reset),
    .game_frame_clk_rising_edge (game_frame_clk_rising_edge),
    .is_moving                  (is_moving),
    .hit                        (hit),
    .anim_frame                 (anim_frame),
    .hidden                     (hidden)
  );

  // Unsigned wrap makes pixels left of / above the player look far away.
  always_comb begin
    lx       = DrawX - player_x;
    ly       = DrawY - player_y;
    in_box   = (lx < 10'(SPRITE_W)) && (ly < 10'(SPRITE_H));
    addr_dir = direction;
    addr_x   = lx[XW-1:0];
`ifdef PLAYER_MIRROR_EN
    if (direction == DIR_LEFT) begin
      addr_dir = DIR_RIGHT;
      addr_x   = XW'(SPRITE_W - 1) - lx[XW-1:0];
    end
`endif
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rom_addr     <= '0;
      in_box1      <= 1'b0;
      hidden1      <= 1'b0;
      in_box2      <= 1'b0;
      hidden2      <= 1'b0;
      is_player    <= 1'b0;
      player_index <= TRANSPARENT_IDX;
    end else begin
      rom_addr     <= {addr_dir, anim_frame, ly[YW-1:0], addr_x};
      in_box1      <= in_box;
      hidden1      <= hidden;
      // rom_data for the stage-1 address is registered by the ROM alongside this stage
      in_box2      <= in_box1;
      hidden2      <= hidden1;
      is_player    <= in_box2 && !hidden2;
      player_index <= (in_box2 && !hidden2) ? rom_data : TRANSPARENT_IDX;
    end
  end

endmodule

// File: tb/tb_player_sprite_engine.sv
// tb/tb_player_sprite_engine.sv - directed vector bench for player_sprite_engine
module tb_player_sprite_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [9:0]  draw_x = '0, draw_y = '0, px = '0, py = '0;
  logic [1:0]  dir = '0;
  logic        moving = 1'b0;
  logic        hit = 1'b0;
  logic [13:0] rom_addr;
  logic [4:0]  rom_data = '0;
  logic        is_player;
  logic [4:0]  player_index;
  logic [1:0]  anim_frame;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Synchronous ROM model: data is a fixed function of the address.
  always @(posedge clk)
    rom_data <= 5'(rom_addr[4:0] + rom_addr[9:5] + {1'b0, rom_addr[13:10]});

  player_sprite_engine dut (
    .Clk                        (clk),
    .Reset                      (rst_n),
    .game_frame_clk_rising_edge (tick),
    .DrawX                      (draw_x),
    .DrawY                      (draw_y),
    .player_x                   (px),
    .player_y                   (py),
    .direction                  (dir),
    .is_moving                  (moving),
    .hit                        (hit),
    .rom_addr                   (rom_addr),
    .rom_data                   (rom_data),
    .is_player                  (is_player),
    .player_index               (player_index),
    .anim_frame                 (anim_frame)
  );

  typedef struct {
    logic [1:0] d;
    logic [9:0] px, py, dx, dy;
    int         addr;
    int         isp;
    int         idx;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_pulse();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic hit_pulse();
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
  endtask

  task automatic set_pix(input logic [1:0] d, input logic [9:0] x0, input logic [9:0] y0,
                         input logic [9:0] x, input logic [9:0] y);
    dir = d; px = x0; py = y0; draw_x = x; draw_y = y;
  endtask

  initial begin
    vt[0]  = '{2'd0, 10'd100, 10'd50, 10'd131, 10'd81, 1023, 1, 30};
    vt[1]  = '{2'd0, 10'd100, 10'd50, 10'd132, 10'd81, 992, 0, 0};
    vt[2]  = '{2'd0, 10'd630, 10'd50, 10'd5, 10'd60, 335, 0, 0};
    vt[3]  = '{2'd0, 10'd0, 10'd0, 10'd31, 10'd0, 31, 1, 31};
    vt[4]  = '{2'd1, 10'd200, 10'd100, 10'd205, 10'd103, 4197, 1, 12};
    vt[5]  = '{2'd2, 10'd200, 10'd100, 10'd200, 10'd100, 8192, 1, 8};
`ifdef PLAYER_MIRROR_EN
    vt[6]  = '{2'd3, 10'd10, 10'd20, 10'd12, 10'd27, 8445, 1, 12};
    vt[11] = '{2'd3, 10'd300, 10'd300, 10'd300, 10'd301, 8255, 1, 8};
`else
    vt[6]  = '{2'd3, 10'd10, 10'd20, 10'd12, 10'd27, 12514, 1, 21};
    vt[11] = '{2'd3, 10'd300, 10'd300, 10'd300, 10'd301, 12320, 1, 13};
`endif
    vt[7]  = '{2'd0, 10'd100, 10'd50, 10'd99, 10'd60, 351, 0, 0};
    vt[8]  = '{2'd0, 10'd100, 10'd50, 10'd110, 10'd49, 1002, 0, 0};
    vt[9]  = '{2'd0, 10'd100, 10'd50, 10'd100, 10'd82, 0, 0, 0};
    vt[10] = '{2'd0, 10'd100, 10'd50, 10'd100, 10'd50, 0, 1, 0};

    // Reset state
    set_pix(2'd0, 10'd100, 10'd50, 10'd131, 10'd81);
    cycles(3);
    check("reset_rom_addr", int'(rom_addr), 0);
    check("reset_is_player", int'(is_player), 0);
    check("reset_index", int'(player_index), 0);
    check("reset_frame", int'(anim_frame), 0);
    rst_n = 1'b1;

    // Exact latency: outside -> inside, visible only after the third edge
    set_pix(2'd0, 10'd100, 10'd50, 10'd132, 10'd81);
    cycles(4);
    draw_x = 10'd131;
    cycles(2);
    check("latency_edge2", int'(is_player), 0);
    cycles(1);
    check("latency_edge3", int'(is_player), 1);
    check("latency_index", int'(player_index), 30);

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      set_pix(vt[i].d, vt[i].px, vt[i].py, vt[i].dx, vt[i].dy);
      cycles(4);
      check($sformatf("vec%0d_addr", i), int'(rom_addr), vt[i].addr);
      check($sformatf("vec%0d_is_player", i), int'(is_player), vt[i].isp);
      check($sformatf("vec%0d_index", i), int'(player_index), vt[i].idx);
    end

    // Walk animation: after k ticks of moving, frame = ((k-1)/8) mod 4
    moving = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      tick_pulse();
      check($sformatf("walk_tick%0d", k), int'(anim_frame), ((k - 1) / 8) % 4);
    end
    cycles(3);
    check("walk_stable_between_ticks", int'(anim_frame), 1);
    moving = 1'b0;
    tick_pulse();
    check("walk_stop", int'(anim_frame), 0);

    // Flash blink: after t ticks count = 16-t, hidden while bit 2 set, NORMAL at t=15
    set_pix(2'd0, 10'd100, 10'd50, 10'd131, 10'd81);
    hit_pulse();
    cycles(4);
    check("flash_t0", int'(is_player), 1);
    for (int t = 1; t <= 16; t++) begin
      tick_pulse();
      cycles(4);
      check($sformatf("flash_t%0d", t), int'(is_player),
            ((t < 15) && (((16 - t) & 4) != 0)) ? 0 : 1);
    end

    // Hit during FLASH restarts the count
    hit_pulse();
    repeat (5) tick_pulse();
    cycles(4);
    check("restart_before", int'(is_player), 1);
    hit_pulse();
    cycles(4);
    check("restart_load", int'(is_player), 1);
    tick_pulse();
    cycles(4);
    check("restart_tick1", int'(is_player), 0);
    repeat (14) tick_pulse();
    cycles(4);
    check("restart_drained", int'(is_player), 1);

    // Hit coincident with a tick: load wins, count is 16
    @(negedge clk) begin hit = 1'b1; tick = 1'b1; end
    @(negedge clk) begin hit = 1'b0; tick = 1'b0; end
    cycles(4);
    check("coincident_load", int'(is_player), 1);
    tick_pulse();
    cycles(4);
    check("coincident_tick1", int'(is_player), 0);

    // Async reset mid-WALK and mid-FLASH
    moving = 1'b1;
    repeat (10) tick_pulse();
    cycles(4);
    check("pre_reset_frame", int'(anim_frame), 1);
    check("pre_reset_hidden", int'(is_player), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_addr", int'(rom_addr), 0);
    check("async_rst_is_player", int'(is_player), 0);
    check("async_rst_index", int'(player_index), 0);
    check("async_rst_frame", int'(anim_frame), 0);
    moving = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    cycles(4);
    check("post_reset_visible", int'(is_player), 1);
    check("post_reset_frame", int'(anim_frame), 0);
    moving = 1'b1;
    repeat (8) tick_pulse();
    check("post_reset_walk8", int'(anim_frame), 0);
    tick_pulse();
    check("post_reset_walk9", int'(anim_frame), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
